my_rx_uart: RTL and testbench

MY_RX_UART -- requirements
Module: my_rx_uart

---
 rtl/my_rx_uart.sv | 84 ++++++++
 tb/tb_my_rx_uart.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/my_rx_uart.sv
// my_rx_uart: 8N1 serial receiver with a 2-flop synchronizer, glitch rejection and frame-error detection.
// A received byte is held in rx_data until it is acknowledged; overrun flags a byte lost to a newer one.
module my_rx_uart #(
   parameter int SYSTEM_CLK_MHZ = 25,
   parameter int BAUDRATE = 9600
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_in,
   input  logic       rx_ack,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       overrun,
   output logic       frame_err,
   output logic       busy
);
   localparam int CYCLES_PER_SYMBOL = SYSTEM_CLK_MHZ * 1000000 / BAUDRATE;
   localparam int HALF_SYMBOL = CYCLES_PER_SYMBOL / 2;
   localparam int CW = $clog2(CYCLES_PER_SYMBOL + 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

   state_t state, state_nxt;
   logic rx_m, rx_s;
   logic [CW-1:0] cnt;
   logic [2:0] bit_idx;
   logic [7:0] shift;
   logic sample, done, ack;

   always_comb begin
      sample = cnt == CW'(1);
      done = state == STOP && sample && rx_s;
      ack = rx_ack && rx_valid;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         state <= IDLE;
         cnt <= '0;
         bit_idx <= '0;
         shift <= '0;
         rx_data <= '0;
         rx_valid <= 1'b0;
         overrun <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_m <= rx_in;
         rx_s <= rx_m;
         state <= state_nxt;
         frame_err <= state == STOP && sample && !rx_s;
         if (state == IDLE && !rx_s)
            cnt <= CW'(HALF_SYMBOL);
         else if (state == START || state == DATA || state == STOP)
            cnt <= sample ? CW'(CYCLES_PER_SYMBOL) : cnt - CW'(1);
         if (state == START && sample)
            bit_idx <= '0;
         if (state == DATA && sample) begin
            shift[bit_idx] <= rx_s;
            bit_idx <= bit_idx + 3'd1;
         end
         if (done)
            rx_data <= shift;
         // a completing byte wins over a same-cycle ack, which only suppresses overrun
         rx_valid <= done || (rx_valid && !rx_ack);
         overrun <= !ack && (overrun || (done && rx_valid));
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (!rx_s) state_nxt = START;
         START:     if (sample) state_nxt = rx_s ? IDLE : DATA;
         DATA:      if (sample && bit_idx == 3'd7) state_nxt = STOP;
         STOP:      if (sample) state_nxt = rx_s ? IDLE : WAIT_IDLE;
         WAIT_IDLE: if (rx_s) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb busy = state != IDLE;
endmodule

// File: tb/tb_my_rx_uart.sv
// tb_my_rx_uart: table-driven frames plus hand sequences and a randomized run against a byte-level model.
module tb_my_rx_uart;
   logic clk = 1'b0, reset = 1'b1, rx_in = 1'b1, rx_ack = 1'b0;
   logic [7:0] rx_data;
   logic rx_valid, overrun, frame_err, busy;
   int n_pass = 0, n_total = 0, fe_cnt = 0;

   typedef struct {
      bit is_ack;
      logic [7:0] data;
      bit stop;
      logic [7:0] e_data;
      bit e_valid;
      bit e_ovr;
      int e_fe;
   } vec_t;

   vec_t vecs[10];

   my_rx_uart #(.SYSTEM_CLK_MHZ(1), .BAUDRATE(100000)) dut (
      .clk(clk), .reset(reset), .rx_in(rx_in), .rx_ack(rx_ack),
      .rx_data(rx_data), .rx_valid(rx_valid), .overrun(overrun),
      .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(negedge clk) if (frame_err) fe_cnt <= fe_cnt + 1;

   function automatic vec_t mk(bit a, logic [7:0] d, bit s, logic [7:0] ed, bit ev, bit eo, int ef);
      mk.is_ack = a; mk.data = d; mk.stop = s;
      mk.e_data = ed; mk.e_valid = ev; mk.e_ovr = eo; mk.e_fe = ef;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic check_outs(input string tag, input logic [7:0] d, input bit v, input bit o,
                             input int fe_exp, input int fe0);
      chk($sformatf("%s rx_data", tag), rx_data, d);
      chk($sformatf("%s rx_valid", tag), rx_valid, v);
      chk($sformatf("%s overrun", tag), overrun, o);
      chk($sformatf("%s busy", tag), busy, 0);
      chk($sformatf("%s frame_err pulses", tag), fe_cnt - fe0, fe_exp);
   endtask

   // one 8N1 frame of 10 clocks per bit; a bad stop may be held low for extra cycles
   task automatic send_frame(input logic [7:0] b, input bit stop, input int hold);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      @(posedge clk);
      for (int i = 0; i < 10; i++) begin
         #1 rx_in = f[i];
         repeat (10) @(posedge clk);
      end
      repeat (hold) @(posedge clk);
      #1 rx_in = 1'b1;
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic do_ack();
      @(posedge clk);
      #1 rx_ack = 1'b1;
      @(posedge clk);
      #1 rx_ack = 1'b0;
   endtask

   initial begin
      logic [7:0] m_data, b;
      bit m_valid, m_ovr, good;
      int fe0;
      vecs[0] = mk(0, 8'h55, 1, 8'h55, 1, 0, 0);
      vecs[1] = mk(1, 8'h00, 1, 8'h55, 0, 0, 0);
      vecs[2] = mk(0, 8'h12, 1, 8'h12, 1, 0, 0);
      vecs[3] = mk(0, 8'h34, 1, 8'h34, 1, 1, 0);
      vecs[4] = mk(1, 8'h00, 1, 8'h34, 0, 0, 0);
      vecs[5] = mk(0, 8'hA3, 0, 8'h34, 0, 0, 1);
      vecs[6] = mk(1, 8'h00, 1, 8'h34, 0, 0, 0);
      vecs[7] = mk(0, 8'h00, 1, 8'h00, 1, 0, 0);
      vecs[8] = mk(0, 8'hFF, 1, 8'hFF, 1, 1, 0);
      vecs[9] = mk(1, 8'h00, 1, 8'hFF, 0, 0, 0);

      repeat (3) @(posedge clk);
      #1;
      check_outs("reset", 8'h00, 0, 0, 0, fe_cnt);
      chk("reset frame_err", frame_err, 0);
      reset = 1'b0;
      repeat (3) @(posedge clk);

      foreach (vecs[i]) begin
         fe0 = fe_cnt;
         if (vecs[i].is_ack) do_ack();
         else send_frame(vecs[i].data, vecs[i].stop, 0);
         check_outs($sformatf("row%0d", i), vecs[i].e_data, vecs[i].e_valid, vecs[i].e_ovr, vecs[i].e_fe, fe0);
      end

      // short low glitch: START entered, then rejected
      fe0 = fe_cnt;
      @(posedge clk);
      #1 rx_in = 1'b0;
      repeat (3) @(posedge clk);
      #1 rx_in = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("glitch busy in START", busy, 1);
      repeat (15) @(posedge clk);
      #1 check_outs("glitch", 8'hFF, 0, 0, 0, fe0);

      // bad stop with line held low: one error, no retrigger while low
      fe0 = fe_cnt;
      send_frame(8'hA3, 0, 30);
      check_outs("break", 8'hFF, 0, 0, 1, fe0);
      repeat (100) @(posedge clk);
      #1 check_outs("break idle", 8'hFF, 0, 0, 1, fe0);

      // ack on the exact completion cycle of a byte
      send_frame(8'h12, 1, 0);
      send_frame(8'h34, 1, 0);
      check_outs("pre-coincident", 8'h34, 1, 1, 0, fe_cnt);
      fork
         send_frame(8'h9C, 1, 0);
         begin
            @(posedge clk);
            repeat (97) @(posedge clk);
            #1 rx_ack = 1'b1;
            @(posedge clk);
            #1 rx_ack = 1'b0;
            chk("coincident rx_data", rx_data, 8'h9C);
            chk("coincident rx_valid", rx_valid, 1);
            chk("coincident overrun", overrun, 0);
         end
      join

      // reset during data bit 4 of 0xFF, then a clean frame
      fe0 = fe_cnt;
      fork
         send_frame(8'hFF, 1, 0);
         begin
            @(posedge clk);
            repeat (55) @(posedge clk);
            #1 reset = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            check_outs("mid reset", 8'h00, 0, 0, 0, fe0);
            reset = 1'b0;
         end
      join
      check_outs("after abort", 8'h00, 0, 0, 0, fe0);
      fe0 = fe_cnt;
      send_frame(8'h0F, 1, 0);
      check_outs("clean 0F", 8'h0F, 1, 0, 0, fe0);

      m_data = 8'h0F; m_valid = 1; m_ovr = 0;
      for (int i = 0; i < 8; i++) begin
         b = 8'($urandom_range(0, 255));
         good = $urandom_range(0, 4) != 0;
         fe0 = fe_cnt;
         send_frame(b, good, 0);
         if (good) begin
            m_ovr = m_ovr | m_valid;
            m_data = b;
            m_valid = 1;
         end
         check_outs($sformatf("rand%0d", i), m_data, m_valid, m_ovr, good ? 0 : 1, fe0);
         if ($urandom_range(0, 1) == 1) begin
            fe0 = fe_cnt;
            do_ack();
            if (m_valid) begin
               m_valid = 0;
               m_ovr = 0;
            end
            check_outs($sformatf("rand%0d ack", i), m_data, m_valid, m_ovr, 0, fe0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
